// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes, light codes, phase indices and head-light decode for traffic_phase_scheduler
package traffic_pkg;
  localparam logic [2:0] ALL_RED = 3'd0, GREEN = 3'd1, YELLOW = 3'd2, FLASH = 3'd3;
  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_DARK   = 2'b10,
    LIGHT_RED    = 2'b11
  } light_t;
  localparam logic [1:0] PH_A_THRU = 2'd0, PH_A_LEFT = 2'd1, PH_B_THRU = 2'd2, PH_B_LEFT = 2'd3;
  function automatic logic [1:0] head_light(input logic [2:0] st, input logic [1:0] ph, input logic blink, input logic [1:0] idx);
    return (st == GREEN && ph == idx) ? LIGHT_GREEN :
           (st == YELLOW && ph == idx) ? LIGHT_YELLOW :
           (st == FLASH && !blink) ? LIGHT_DARK : LIGHT_RED;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled clk cycles by TICK_DIV; ports clk, rst_n (sync active-low), ena (count enable), tick (one-cycle pulse on the last count)
module tick_prescaler #(
  parameter int TICK_DIV = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = ena && cnt == LAST;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (ena) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin four-head signal sequencer; in clk, rst_n, ena, req[3:0], maint; out a_light, a_lt_light, b_light, b_lt_light, phase, state, pending, tick
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 12000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic       maint,
  output logic [1:0] a_light,
  output logic [1:0] a_lt_light,
  output logic [1:0] b_light,
  output logic [1:0] b_lt_light,
  output logic [1:0] phase,
  output logic [2:0] state,
  output logic [3:0] pending,
  output logic       tick
);
  localparam logic [CNT_W:0] G_MIN = (CNT_W + 1)'(GREEN_MIN);
  localparam logic [CNT_W:0] G_MAX = (CNT_W + 1)'(GREEN_MAX);
  localparam logic [CNT_W:0] Y_T   = (CNT_W + 1)'(YELLOW_T);
  localparam logic [CNT_W:0] AR_T  = (CNT_W + 1)'(ALLRED_T);
  logic [CNT_W-1:0] timer;
  logic [CNT_W:0]   e;
  logic [2:0]       nxt_state;
  logic [1:0]       nxt_phase, pick;
  logic             blink, other, enter;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .tick (tick)
  );
  assign e = {1'b0, timer} + 1'b1;
  assign other = |(pending & ~(4'b0001 << phase));
  // Scan downwards so the nearest pending phase after the current one wins; k=4 wraps back to the current phase.
  always_comb begin
    pick = 2'd0;
    for (int k = 4; k >= 1; k--)
      if (pending[phase + 2'(k)]) pick = phase + 2'(k);
  end
  always_comb begin
    nxt_state = !tick ? state :
                state == GREEN ? ((maint || (other && (e >= G_MAX || (e >= G_MIN && !req[phase])))) ? YELLOW : GREEN) :
                state == YELLOW ? (e >= Y_T ? ALL_RED : YELLOW) :
                state == FLASH ? (maint ? FLASH : ALL_RED) :
                e >= AR_T ? (maint ? FLASH : GREEN) : ALL_RED;
    enter = nxt_state == GREEN && state != GREEN;
    nxt_phase = enter ? pick : phase;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= ALL_RED;
      phase   <= PH_B_LEFT;
      timer   <= '0;
      pending <= '0;
      blink   <= 1'b1;
    end else begin
      state   <= nxt_state;
      phase   <= nxt_phase;
      timer   <= nxt_state != state ? '0 : (tick && timer != '1) ? timer + 1'b1 : timer;
      pending <= (pending | req) & ~(enter ? 4'b0001 << nxt_phase : 4'b0000);
      blink   <= (nxt_state == FLASH && state != FLASH) ? 1'b1 : (state == FLASH && tick) ? ~blink : blink;
    end
  assign a_light    = head_light(state, phase, blink, PH_A_THRU);
  assign a_lt_light = head_light(state, phase, blink, PH_A_LEFT);
  assign b_light    = head_light(state, phase, blink, PH_B_THRU);
  assign b_lt_light = head_light(state, phase, blink, PH_B_LEFT);
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences a four-head intersection: A through, A left-turn, B through, B left-turn.
- Latches vehicle demand per phase and grants green phases round-robin.
- Enforces min/max green, yellow and all-red clearance timing from a seconds-tick prescaler.
- Drives per-head 2-bit light codes consumed by the 7-segment display encoder; sits between slide-switch inputs and display logic in the Tiny Tapeout wrapper.

Parameters:
- TICK_DIV, 12000000: enabled clk cycles per tick; must be >= 1.
- GREEN_MIN, 5: minimum green, in ticks; must be >= 1.
- GREEN_MAX, 15: maximum green under competing demand, in ticks; must be >= GREEN_MIN.
- YELLOW_T, 3: yellow duration, in ticks; must be >= 1.
- ALLRED_T, 2: all-red clearance, in ticks; must be >= 1.
- CNT_W, 8: width of the phase timer; every time parameter must be < 2^CNT_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ena  in  1  advance enable; low freezes the prescaler and sequencing.
- req  in  4  demand, level: [0] A thru, [1] A left, [2] B thru, [3] B left.
- maint  in  1  maintenance request; enters flashing-red mode.
- a_light, a_lt_light, b_light, b_lt_light  out  2 each  light codes: 00 green, 01 yellow, 11 red, 10 dark.
- phase  out  2  current or last-served phase index.
- state  out  3  FSM state code.
- pending  out  4  latched demand.
- tick  out  1  one-cycle tick pulse.

Interface decision: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - state=ALL_RED, phase=3, timer=0, prescaler=0, pending=0, blink=1, tick=0.
  - All heads read 11 from the following edge.
- Prescaler:
  - When ena=1, count 0..TICK_DIV-1 and wrap.
  - tick=1 for exactly the cycle count==TICK_DIV-1 with ena=1.
  - When ena=0, the count holds and tick=0.
- Timer:
  - Cleared on every state change.
  - Increments on each tick when the state does not change; saturates at 2^CNT_W-1.
  - E = timer+1 is the elapsed-tick count evaluated on a tick.
- Pending:
  - pending[i] is set on any cycle req[i]=1, regardless of ena.
  - pending[i] is cleared on the edge that enters GREEN with phase=i; clear wins over a same-cycle req[i].
- Transitions: all occur only on tick cycles.
  - GREEN, maint=1: go to YELLOW.
  - GREEN, some pending[j] with j!=phase: go to YELLOW when E>=GREEN_MAX, or when E>=GREEN_MIN and req[phase]=0.
  - GREEN, no other pending: stay (rest on green).
  - YELLOW: E>=YELLOW_T goes to ALL_RED.
  - ALL_RED, E>=ALLRED_T and maint=1: go to FLASH.
  - ALL_RED, E>=ALLRED_T, otherwise: go to GREEN with phase = first pending index searching phase+1, phase+2, ... mod 4. If none are pending, phase=0.
  - FLASH: blink toggles each tick. maint=0 on a tick goes to ALL_RED.
- Light decode: combinational from registered state, phase and blink only; there is no path from inputs to outputs.
  - GREEN: head[phase]=00, others 11.
  - YELLOW: head[phase]=01, others 11.
  - ALL_RED: all 11.
  - FLASH: all 11 when blink=1, all 10 when blink=0.
  - Entering FLASH sets blink=1.
- Safety invariant: at most one head is non-red at any cycle, and green is never followed directly by green.

Decomposition:
- traffic_pkg holds:
  - state enum: ALL_RED=0, GREEN=1, YELLOW=2, FLASH=3.
  - light codes: LIGHT_GREEN, LIGHT_YELLOW, LIGHT_DARK, LIGHT_RED.
  - phase index constants.
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst_n, ena, tick).

Test Plan: all scenarios use TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1.
1. Reset, req=0, ena=1 -> all heads 11 and state ALL_RED. First tick 4 cycles after reset release; next edge GREEN phase 0, a_light=00; remains green for 100 cycles.
2. In phase-0 green, pulse req[2] for 1 cycle, req[0]=0 -> pending=0100. Yellow (a_light=01) after 3 green ticks, for 2 ticks. All-red for 1 tick. Then b_light=00, phase=2, pending=0000.
3. As scenario 2 but req[0] held high -> green lasts exactly 6 ticks (24 cycles) before yellow.
4. Phase-0 green, set pending=1010 -> served order phase 1 then phase 3. Rests on phase 3 green with pending=0000.
5. maint=1 at green E=1 -> yellow on next tick (min ignored), then all-red, then FLASH. Heads alternate 11/10 every tick. maint=0 -> ALL_RED 1 tick, then GREEN.
6. Hold ena=0 for 20 cycles mid-yellow -> state, timer and prescaler unchanged, and a req[1] pulse still sets pending[1]. Then rst_n=0 for 1 cycle -> next edge all heads 11, phase=3, pending=0.
